// File: rtl/steer_ctrl.sv
// PD steering law with TRACK/HOLD/SEARCH recovery and a glitch-free servo PWM; 2-cycle command latency, no backpressure.
// Derivative term and its registers exist only when STEER_DERIV_EN is defined.
module steer_ctrl #(
  parameter int IMG_W            = 640,
  parameter int KP               = 4,
  parameter int KD               = 2,
  parameter int GAIN_SHIFT       = 4,
  parameter int LOST_HOLD_FRAMES = 8,
  parameter int SEARCH_CMD       = 96,
  parameter int PWM_DIV          = 16,
  localparam int X_W             = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    centroid_x,
  input  logic              line_valid,
  input  logic              line_lost,
  output logic signed [7:0] steer_cmd,
  output logic              steer_valid,
  output logic [1:0]        state,
  output logic              pwm_out
);

  localparam int E_W   = X_W + 1;
  localparam int SUM_W = X_W + 18;
  localparam int CNT_W = $clog2(LOST_HOLD_FRAMES + 1);
  localparam int PRE_W = $clog2(PWM_DIV + 1);
  localparam logic signed [E_W-1:0]   SETPOINT = E_W'(IMG_W >> 1);
  localparam logic signed [SUM_W-1:0] KP_S     = SUM_W'(KP);
  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(-127);
  localparam logic signed [7:0]       SRCH_P   = 8'(SEARCH_CMD);
  localparam logic signed [7:0]       SRCH_N   = 8'(-SEARCH_CMD);

  typedef enum logic [1:0] {TRACK = 2'd0, HOLD = 2'd1, SEARCH = 2'd2} st_t;

  st_t                     st_q, st_d;
  logic [CNT_W-1:0]        lost_cnt, cnt_d;
  logic signed [E_W-1:0]   err_now, s1_err;
  logic                    s1_vld;
  logic signed [SUM_W-1:0] err_ext, sum, shifted;
  logic signed [7:0]       pd_cmd, cmd_d, last_cmd;
  logic                    last_neg;

  assign state   = st_q;
  assign err_now = $signed({1'b0, centroid_x}) - SETPOINT;

  always_comb begin
    st_d  = st_q;
    cnt_d = lost_cnt;
    if (line_valid) begin
      if (!line_lost) begin
        st_d  = TRACK;
        cnt_d = '0;
      end else begin
        case (st_q)
          TRACK: begin
            cnt_d = CNT_W'(1);
            st_d  = (LOST_HOLD_FRAMES == 1) ? SEARCH : HOLD;
          end
          HOLD: begin
            cnt_d = lost_cnt + CNT_W'(1);
            if (cnt_d == CNT_W'(LOST_HOLD_FRAMES)) st_d = SEARCH;
          end
          default: st_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= TRACK;
      lost_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_err   <= '0;
    end else begin
      st_q     <= st_d;
      lost_cnt <= cnt_d;
      s1_vld   <= line_valid;
      if (line_valid) s1_err <= err_now;
    end
  end

  assign err_ext = {{(SUM_W-E_W){s1_err[E_W-1]}}, s1_err};

`ifdef STEER_DERIV_EN
  localparam logic signed [SUM_W-1:0] KD_S = SUM_W'(KD);
  logic signed [E_W-1:0]   err_prev;
  logic                    have_prev;
  logic signed [E_W:0]     diff_now, s1_diff;
  logic signed [SUM_W-1:0] diff_ext;

  assign diff_now = have_prev ? $signed({err_now[E_W-1], err_now} - {err_prev[E_W-1], err_prev}) : '0;
  assign diff_ext = {{(SUM_W-E_W-1){s1_diff[E_W]}}, s1_diff};

  // err_prev advances alongside stage 1 so back-to-back strobes each see their predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_prev  <= '0;
      have_prev <= 1'b0;
      s1_diff   <= '0;
    end else if (line_valid) begin
      s1_diff <= diff_now;
      if (line_lost) begin
        have_prev <= 1'b0;
      end else begin
        err_prev  <= err_now;
        have_prev <= 1'b1;
      end
    end
  end

  assign sum = err_ext * KP_S + diff_ext * KD_S;
`else
  assign sum = err_ext * KP_S;
`endif

  assign shifted = sum >>> GAIN_SHIFT;

  always_comb begin
    pd_cmd = shifted[7:0];
    if (shifted > SAT_HI)      pd_cmd = 8'sd127;
    else if (shifted < SAT_LO) pd_cmd = -8'sd127;
  end

  // st_q already holds this frame's post-transition state when stage 2 runs.
  always_comb begin
    cmd_d = pd_cmd;
    case (st_q)
      HOLD:    cmd_d = last_cmd;
      SEARCH:  cmd_d = last_neg ? SRCH_N : SRCH_P;
      default: cmd_d = pd_cmd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steer_cmd   <= '0;
      steer_valid <= 1'b0;
      last_cmd    <= '0;
      last_neg    <= 1'b0;
    end else begin
      steer_valid <= s1_vld;
      if (s1_vld) begin
        steer_cmd <= cmd_d;
        if (st_q == TRACK) begin
          last_cmd <= pd_cmd;
          if (pd_cmd != 8'sd0) last_neg <= pd_cmd[7];
        end
      end
    end
  end

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt, duty;
  logic             pre_wrap;

  assign pre_wrap = (pre_cnt == PRE_W'(PWM_DIV - 1));

  // Duty only reloads at the period boundary so a pulse is never truncated mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      duty    <= 8'd128;
      pwm_out <= 1'b0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
      if (pre_wrap) pwm_cnt <= pwm_cnt + 8'd1;
      if (pre_wrap && pwm_cnt == 8'hFF) duty <= {~steer_cmd[7], steer_cmd[6:0]};
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_steer_ctrl.sv
// Bench for steer_ctrl: frame-level reference model plus directed literal checks and PWM pulse measurement.
`timescale 1ns/1ps
module tb_steer_ctrl;
  localparam int X_W = 10;
`ifdef STEER_DERIV_EN
  localparam bit DERIV = 1'b1;
`else
  localparam bit DERIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [X_W-1:0] centroid_x = '0;
  logic line_valid = 1'b0;
  logic line_lost = 1'b0;
  logic signed [7:0] cmd_a, cmd_b;
  logic vld_a, vld_b, pwm_a, pwm_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  steer_ctrl #(.KP(4), .PWM_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .centroid_x(centroid_x), .line_valid(line_valid), .line_lost(line_lost),
    .steer_cmd(cmd_a), .steer_valid(vld_a), .state(st_a), .pwm_out(pwm_a));

  steer_ctrl #(.KP(16)) dut_b (
    .clk(clk), .rst(rst), .centroid_x(centroid_x), .line_valid(line_valid), .line_lost(line_lost),
    .steer_cmd(cmd_b), .steer_valid(vld_b), .state(st_b), .pwm_out(pwm_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-instance PD state, shared lost-run counter.
  int KPS [2] = '{4, 16};
  int m_prev [2];
  bit m_have [2];
  int m_last [2];
  int m_dir [2];
  int m_run;

  typedef struct { int due; int ca; int cb; } exp_t;
  exp_t q[$];
  exp_t cmp_e;
  int exp_state;
  int exp_cmd [2];
  bit cmp_due;
  int cmp_err;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 0; m_have[i] = 0; m_last[i] = 0; m_dir[i] = 1; exp_cmd[i] = 0;
    end
    m_run = 0;
    exp_state = 0;
    q.delete();
  endtask

  function automatic int track_cmd(int i, int err);
    int d;
    int s;
    d = (DERIV && m_have[i]) ? err - m_prev[i] : 0;
    s = (KPS[i] * err + 2 * d) >>> 4;
    if (s > 127) s = 127;
    if (s < -127) s = -127;
    m_prev[i] = err;
    m_have[i] = 1;
    m_last[i] = s;
    if (s != 0) m_dir[i] = (s > 0) ? 1 : -1;
    return s;
  endfunction

  function automatic int lost_cmd(int i);
    m_have[i] = 0;
    return (m_run >= 8) ? 96 * m_dir[i] : m_last[i];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      chk("rst_valid", int'(vld_a) + int'(vld_b), 0);
      chk("rst_cmd_a", int'(cmd_a), 0);
      chk("rst_cmd_b", int'(cmd_b), 0);
      chk("rst_state", int'(st_a) + int'(st_b), 0);
      chk("rst_pwm", int'(pwm_a) + int'(pwm_b), 0);
    end else begin
      cmp_due = (q.size() > 0) && (q[0].due == cyc);
      if (cmp_due) begin
        exp_cmd[0] = q[0].ca;
        exp_cmd[1] = q[0].cb;
        q.pop_front();
      end
      chk("valid_a", int'(vld_a), int'(cmp_due));
      chk("valid_b", int'(vld_b), int'(cmp_due));
      chk("cmd_a", int'(cmd_a), exp_cmd[0]);
      chk("cmd_b", int'(cmd_b), exp_cmd[1]);
      chk("state_a", int'(st_a), exp_state);
      chk("state_b", int'(st_b), exp_state);
      if (line_valid) begin
        cmp_err = int'(centroid_x) - 320;
        cmp_e.due = cyc + 2;
        if (line_lost) begin
          m_run++;
          exp_state = (m_run >= 8) ? 2 : 1;
          cmp_e.ca = lost_cmd(0);
          cmp_e.cb = lost_cmd(1);
        end else begin
          m_run = 0;
          exp_state = 0;
          cmp_e.ca = track_cmd(0, cmp_err);
          cmp_e.cb = track_cmd(1, cmp_err);
        end
        q.push_back(cmp_e);
      end
    end
  end

  // PWM pulse monitor on dut_a: high widths and rise-to-rise periods.
  int hi_q[$];
  int per_q[$];
  int last_rise = 0;
  bit pwm_prev = 1'b0;
  always @(negedge clk) begin
    if (pwm_a && !pwm_prev) begin
      per_q.push_back(cyc - last_rise);
      last_rise = cyc;
    end
    if (!pwm_a && pwm_prev) hi_q.push_back(cyc - last_rise);
    pwm_prev = pwm_a;
  end

  task automatic frame(int x, bit lost);
    @(posedge clk); #1;
    centroid_x = X_W'(x);
    line_lost  = lost;
    line_valid = 1'b1;
    @(posedge clk); #1;
    line_valid = 1'b0;
    line_lost  = 1'($urandom);
    centroid_x = X_W'($urandom);
  endtask

  task automatic frame_lit(string nm, int x, bit lost, int inst, int exp_cmd_v, int exp_st);
    frame(x, lost);
    @(negedge clk);
    chk({nm, "_state"}, (inst == 0) ? int'(st_a) : int'(st_b), exp_st);
    @(negedge clk);
    chk({nm, "_valid"}, (inst == 0) ? int'(vld_a) : int'(vld_b), 1);
    chk({nm, "_cmd"}, (inst == 0) ? int'(cmd_a) : int'(cmd_b), exp_cmd_v);
  endtask

  task automatic wait_hi(int n);
    for (int i = 0; i < 1200 && hi_q.size() < n; i++) @(negedge clk);
    chk("pwm_pulse_seen", int'(hi_q.size() >= n), 1);
  endtask

  int lostp [3] = '{10, 70, 35};

  initial begin
    model_reset();
    @(negedge clk);
    chk("lit_rst_cmd", int'(cmd_a), 0);
    chk("lit_rst_state", int'(st_a), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    frame_lit("f400a", 400, 0, 0, 20, 0);
    frame_lit("f400b", 400, 0, 0, 20, 0);
    frame_lit("f432", 432, 0, 0, DERIV ? 32 : 28, 0);
    frame_lit("hold0", 0, 1, 0, DERIV ? 32 : 28, 1);
    frame_lit("f400c", 400, 0, 0, 20, 0);
    for (int i = 1; i <= 10; i++) frame_lit("lostseq", 0, 1, 0, (i >= 8) ? 96 : 20, (i >= 8) ? 2 : 1);
    frame_lit("recover", 400, 0, 0, 20, 0);
    frame_lit("hold1", 0, 1, 0, 20, 1);
    frame_lit("f192", 192, 0, 0, -32, 0);
    for (int i = 1; i <= 8; i++) frame_lit("lostneg", 0, 1, 0, (i >= 8) ? -96 : -32, (i >= 8) ? 2 : 1);
    frame_lit("sat_hi", 639, 0, 1, 127, 0);
    frame_lit("sat_lo", 0, 0, 1, -127, 0);
    frame_lit("hold2", 0, 1, 1, -127, 1);
    frame_lit("center", 320, 0, 1, 0, 0);

    frame_lit("pwm_hold", 0, 1, 0, 0, 1);
    repeat (300) @(negedge clk);
    hi_q.delete();
    per_q.delete();
    wait_hi(2);
    chk("pwm_hi_cmd0_a", hi_q[0], 128);
    chk("pwm_hi_cmd0_b", hi_q[1], 128);
    chk("pwm_period0", per_q[0], 256);

    per_q.delete();
    for (int i = 0; i < 600 && per_q.size() < 1; i++) @(negedge clk);
    hi_q.delete();
    repeat (40) @(negedge clk);
    frame_lit("pwm_cmd64", 576, 0, 0, 64, 0);
    wait_hi(2);
    chk("pwm_hi_midchange", hi_q[0], 128);
    chk("pwm_hi_next", hi_q[1], 192);
    chk("pwm_period1", per_q[per_q.size() - 1], 256);

    @(posedge clk); #1;
    centroid_x = X_W'(500);
    line_lost  = 1'b1;
    line_valid = 1'b1;
    @(posedge clk); #1;
    line_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_valid", int'(vld_a), 0);
      chk("midrst_cmd", int'(cmd_a), 0);
      chk("midrst_state", int'(st_a), 0);
      chk("midrst_pwm", int'(pwm_a), 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_valid", int'(vld_a), 0);
    end

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        line_valid = ($urandom_range(99) < 60);
        line_lost  = ($urandom_range(99) < lostp[p]);
        centroid_x = X_W'($urandom_range(639));
      end
    end
    @(posedge clk); #1 line_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
